// File: rtl/hazard_pkg.sv
// Shared types and defaults for the register hazard scoreboard.
package hazard_pkg;

  localparam int unsigned NREGS_DEF   = 32;
  localparam int unsigned LAT_MAX_DEF = 4;
  localparam int unsigned PERF_W      = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_PIPE = 2'b01,
    FWD_CPL  = 2'b10
  } fwd_src_e;

  typedef enum logic {
    VAR_IDLE = 1'b0,
    VAR_BUSY = 1'b1
  } var_state_e;

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: pending flag, variable-latency flag and countdown.
module sb_entry #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_set,
  input  logic             i_set_var,
  input  logic [CNT_W-1:0] i_set_cnt,
  input  logic             i_cpl_hit,
  output logic             o_pending,
  output logic             o_var,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_clr_c
);

  logic             r_pending;
  logic             r_var;
  logic [CNT_W-1:0] r_cnt;

  // Entry retires on its last countdown cycle or on its completion.
  assign o_clr_c = r_pending & (r_var ? i_cpl_hit : (r_cnt == CNT_W'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_var     <= 1'b0;
      r_cnt     <= '0;
    end else if (i_set) begin
      r_pending <= 1'b1;
      r_var     <= i_set_var;
      r_cnt     <= i_set_var ? '0 : i_set_cnt;
    end else if (o_clr_c) begin
      r_pending <= 1'b0;
      r_var     <= 1'b0;
      r_cnt     <= '0;
    end else if (r_pending && !r_var) begin
      r_cnt     <= r_cnt - CNT_W'(1);
    end
  end

  assign o_pending = r_pending;
  assign o_var     = r_var;
  assign o_cnt     = r_cnt;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: RAW/WAW/structural stall and bypass select for ID.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NREGS   = NREGS_DEF,
  parameter int unsigned LAT_MAX = LAT_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         id_valid,
  input  logic [$clog2(NREGS)-1:0]     id_rs1,
  input  logic [$clog2(NREGS)-1:0]     id_rs2,
  input  logic [$clog2(NREGS)-1:0]     id_rd,
  input  logic                         id_reg_write,
  input  logic [$clog2(LAT_MAX+1)-1:0] id_lat,
  input  logic                         cpl_valid,
  input  logic [$clog2(NREGS)-1:0]     cpl_rd,
  output logic                         stall,
  output logic                         fwd_a,
  output logic                         fwd_b,
  output logic [1:0]                   fwd_a_src,
  output logic [1:0]                   fwd_b_src,
  output logic                         var_busy,
  output logic [PERF_W-1:0]            stall_cycles
);

  localparam int unsigned AW    = $clog2(NREGS);
  localparam int unsigned CNT_W = $clog2(LAT_MAX + 1);

  var_state_e       r_state;
  var_state_e       w_state_nxt;

  logic [NREGS-1:0] w_pend;
  logic [NREGS-1:0] w_var;
  logic [NREGS-1:0] w_clr;
  logic [CNT_W-1:0] w_cnt [NREGS];

  logic             w_busy;
  logic             w_cpl_hit;
  logic             w_var_issue;
  logic             w_accept;
  logic [CNT_W-1:0] w_lat_cl;
  logic             w_stall;
  logic             w_rs1_haz;
  logic             w_rs2_haz;

  assign w_busy      = (r_state == VAR_BUSY);
  // Completion only counts when it targets the outstanding variable-latency entry.
  assign w_cpl_hit   = rst_n & cpl_valid & w_busy & w_pend[cpl_rd] & w_var[cpl_rd];
  assign w_var_issue = id_reg_write & (id_rd != '0) & (id_lat == '0);
  assign w_accept    = rst_n & id_valid & ~w_stall & id_reg_write & (id_rd != '0);
  assign w_lat_cl    = (id_lat > CNT_W'(LAT_MAX)) ? CNT_W'(LAT_MAX) : id_lat;
  assign w_rs1_haz   = (id_rs1 != '0) & w_pend[id_rs1];
  assign w_rs2_haz   = (id_rs2 != '0) & w_pend[id_rs2];

  assign w_pend[0] = 1'b0;
  assign w_var[0]  = 1'b0;
  assign w_clr[0]  = 1'b0;
  assign w_cnt[0]  = '0;

  for (genvar i = 1; i < NREGS; i++) begin : g_entry
    sb_entry #(
      .CNT_W (CNT_W)
    ) u_entry (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_set     (w_accept && (id_rd == AW'(i))),
      .i_set_var (id_lat == '0),
      .i_set_cnt (w_lat_cl),
      .i_cpl_hit (w_cpl_hit && (cpl_rd == AW'(i))),
      .o_pending (w_pend[i]),
      .o_var     (w_var[i]),
      .o_cnt     (w_cnt[i]),
      .o_clr_c   (w_clr[i])
    );
  end

  // Hazard resolution for the instruction sitting in ID.
  always_comb begin
    w_stall   = 1'b0;
    fwd_a     = 1'b0;
    fwd_b     = 1'b0;
    fwd_a_src = 2'(FWD_NONE);
    fwd_b_src = 2'(FWD_NONE);
    if (rst_n && id_valid) begin
      if (w_rs1_haz) begin
        if (!w_var[id_rs1] && (w_cnt[id_rs1] == CNT_W'(1))) begin
          fwd_a     = 1'b1;
          fwd_a_src = 2'(FWD_PIPE);
        end else if (w_var[id_rs1] && w_cpl_hit && (cpl_rd == id_rs1)) begin
          fwd_a     = 1'b1;
          fwd_a_src = 2'(FWD_CPL);
        end else begin
          w_stall   = 1'b1;
        end
      end
      if (w_rs2_haz) begin
        if (!w_var[id_rs2] && (w_cnt[id_rs2] == CNT_W'(1))) begin
          fwd_b     = 1'b1;
          fwd_b_src = 2'(FWD_PIPE);
        end else if (w_var[id_rs2] && w_cpl_hit && (cpl_rd == id_rs2)) begin
          fwd_b     = 1'b1;
          fwd_b_src = 2'(FWD_CPL);
        end else begin
          w_stall   = 1'b1;
        end
      end
      if (id_reg_write && (id_rd != '0) && w_pend[id_rd] && !w_clr[id_rd]) begin
        w_stall = 1'b1;
      end
      if (w_var_issue && w_busy && !w_cpl_hit) begin
        w_stall = 1'b1;
      end
    end
  end

  assign stall = w_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= VAR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A new variable issue keeps the unit busy even if the old one completes now.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      VAR_IDLE: begin
        if (w_accept && w_var_issue) begin
          w_state_nxt = VAR_BUSY;
        end
      end
      VAR_BUSY: begin
        if (w_accept && w_var_issue) begin
          w_state_nxt = VAR_BUSY;
        end else if (w_cpl_hit) begin
          w_state_nxt = VAR_IDLE;
        end
      end
      default: w_state_nxt = VAR_IDLE;
    endcase
  end

  assign var_busy = w_busy & rst_n;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter NREGS, default 32, number of architectural registers; register 0 hardwired zero.
REQ-002 SHALL have parameter LAT_MAX, default 4, longest fixed latency; CNT_W = $clog2(LAT_MAX+1).
REQ-003 SHALL have these ports; AW = $clog2(NREGS); one clock; reset synchronous, active-low:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  instruction present in ID.
- id_rs1, id_rs2  in  AW  source registers.
- id_rd  in  AW  destination register.
- id_reg_write  in  1  instruction writes id_rd.
- id_lat  in  CNT_W  fixed latency 1..LAT_MAX; 0 = variable-latency unit.
- cpl_valid  in  1  variable-latency result on completion bus.
- cpl_rd  in  AW  completion destination.
- stall  out  1  hold ID this cycle.
- fwd_a, fwd_b  out  1  bypass source A/B.
- fwd_a_src, fwd_b_src  out  2  00 none, 01 pipeline bypass, 10 completion bus.
- var_busy  out  1  variable-latency op outstanding.
- stall_cycles  out  32  stall counter (REQ-019).

Function
REQ-004 SHALL hold per-register entry {pending, var, cnt[CNT_W]}; register 0 never pending.
REQ-005 SHALL accept an issue when id_valid && !stall; only accepted issues with id_reg_write && id_rd!=0 alter entries.
REQ-006 Fixed issue (id_lat!=0) at edge t SHALL set pending=1, var=0, cnt=min(id_lat,LAT_MAX); cnt decrements each later edge; entry clears on the edge where cnt==1.
REQ-007 Variable issue (id_lat==0) SHALL set pending=1, var=1 and move FSM IDLE->BUSY; entry and FSM (BUSY->IDLE) clear on edge with cpl_valid && cpl_rd matching the var entry.
REQ-008 cpl_valid in IDLE, or with cpl_rd not the var entry, SHALL be ignored.
REQ-009 Source hazard (rsX!=0, pending): fixed with cnt==1 -> fwd_X=1, src 01; var with cpl_valid && cpl_rd==rsX -> fwd_X=1, src 10; otherwise stall=1.
REQ-010 WAW: accepted writer to a pending id_rd SHALL stall unless that entry clears this cycle (cnt==1, or matching completion).
REQ-011 Structural: variable issue while var_busy SHALL stall, unless completion arrives the same cycle.
REQ-012 Same-edge clear and accepted set of one register: set wins.
REQ-013 stall, fwd_*, fwd_*_src SHALL be combinational, zero-latency; all 0 when id_valid=0.
REQ-014 var_busy SHALL equal FSM==BUSY, registered.

Reset
REQ-015 rst_n=0 at an edge SHALL clear all entries, FSM->IDLE, stall_cycles=0, even mid-countdown or with var op outstanding.
REQ-016 While rst_n=0, stall=0, fwd_*=0, fwd_*_src=00, var_busy=0.
REQ-017 cpl_valid during reset SHALL be discarded.

Configuration
REQ-018 Macro HAZARD_PERF_EN SHALL gate the performance counter.
REQ-019 Defined: stall_cycles increments on each edge with stall=1, saturating at 32'hFFFF_FFFF. Undefined: stall_cycles tied to 0, no counter flops.

Structure
REQ-020 Package hazard_pkg SHALL hold fwd_src enum (NONE/PIPE/CPL), var FSM enum (IDLE/BUSY), default NREGS/LAT_MAX.
REQ-021 Sub-module sb_entry (one entry: pending/var/cnt, set/decrement/clear) SHALL be instanced NREGS-1 times.

Verification
REQ-022 Issue rd=5 lat=3 at t; rs1=5 at t+1,t+2 -> stall=1; at t+3 -> stall=0, fwd_a=1, src 01; t+4 -> no hazard.
REQ-023 Var issue rd=7; var_busy=1; rs2=7 stalls until cpl_valid, cpl_rd=7 -> that cycle fwd_b=1, src 10; next cycle var_busy=0.
REQ-024 Second var issue while busy -> stall; same cycle as completion -> accepted, var_busy stays 1.
REQ-025 rd=3 lat=4 pending, writer rd=3 lat=1 -> stall until cnt==1, then accepted, entry 3 cnt=1.
REQ-026 rs1=0, rd=0 with writer of 0 -> never stall/forward; rst_n=0 mid-countdown -> next cycle no hazards, var_busy=0.
REQ-027 With HAZARD_PERF_EN, 10 stall cycles -> stall_cycles=10; preload near max -> saturates; without macro -> 0.
